// File: rtl/lcd_ui_pkg.sv
// Shared constants for the LCD UI blocks: direction indices, grid defaults and
// the per-button FSM encoding.
package lcd_ui_pkg;

    localparam int DIR_UP        = 0;
    localparam int DIR_DOWN      = 1;
    localparam int DIR_LEFT      = 2;
    localparam int DIR_RIGHT     = 3;
    localparam int NUM_DIRS      = 4;

    localparam int GRID_COLS_DEF = 4;
    localparam int GRID_ROWS_DEF = 4;
    localparam int CUR_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HELD_DELAY  = 2'd1,
        ST_HELD_REPEAT = 2'd2
    } btn_state_e;

    // One step on one axis; returns {changed, new_value}. lim is GRID-1.
    function automatic logic [CUR_W:0] cur_step(input logic [CUR_W-1:0] cur,
                                                 input logic             dec,
                                                 input logic [CUR_W-1:0] lim,
                                                 input logic             wrap);
        logic [CUR_W:0] r;
        if (dec) begin
            if (cur == '0) r = wrap ? {1'b1, lim} : {1'b0, cur};
            else           r = {1'b1, cur - 1'b1};
        end else begin
            if (cur >= lim) r = wrap ? {1'b1, {CUR_W{1'b0}}} : {1'b0, cur};
            else            r = {1'b1, cur + 1'b1};
        end
        // A 1-wide axis wraps onto itself: that is not a move.
        r[CUR_W] = r[CUR_W] && (r[CUR_W-1:0] != cur);
        return r;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One direction button: 2-flop synchronizer, debounce counter and the
// press / auto-repeat FSM producing a single-cycle move event.
module btn_conditioner
    import lcd_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 660000,
    parameter int REPEAT_DELAY_CYC = 16500000,
    parameter int REPEAT_RATE_CYC  = 4950000,
    parameter int REPEAT_EN        = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_event
);
    localparam int DB_W   = ($clog2(DEBOUNCE_CYC) < 1) ? 1 : $clog2(DEBOUNCE_CYC);
    localparam int TM_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                 : REPEAT_RATE_CYC;
    localparam int TM_W   = ($clog2(TM_MAX) < 1) ? 1 : $clog2(TM_MAX);

    logic            r_sync1, r_sync2, r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic [TM_W-1:0] r_timer;
    btn_state_e      r_state;
    logic            w_dly_done, w_rate_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_dly_done  = (r_timer == TM_W'(REPEAT_DELAY_CYC - 1));
    assign w_rate_done = (r_timer == TM_W'(REPEAT_RATE_CYC - 1));

    // The event fires in the same cycle the FSM decides to transition.
    always_comb begin
        o_event = 1'b0;
        case (r_state)
            ST_IDLE:        o_event = r_level;
            ST_HELD_DELAY:  o_event = (REPEAT_EN != 0) && r_level && w_dly_done;
            ST_HELD_REPEAT: o_event = r_level && w_rate_done;
            default:        o_event = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (r_level) r_state <= ST_HELD_DELAY;
                end
                ST_HELD_DELAY: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (w_dly_done) begin
                            r_state <= ST_HELD_REPEAT;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                ST_HELD_REPEAT: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else if (w_rate_done) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/keypad_cursor_nav.sv
// Keypad cursor navigation: four conditioned direction buttons arbitrated
// (up > down > left > right) into a bounded grid cursor.
module keypad_cursor_nav
    import lcd_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 660000,
    parameter int REPEAT_DELAY_CYC = 16500000,
    parameter int REPEAT_RATE_CYC  = 4950000,
    parameter int REPEAT_EN        = 1,
    parameter int GRID_COLS        = GRID_COLS_DEF,
    parameter int GRID_ROWS        = GRID_ROWS_DEF,
    parameter int WRAP             = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [CUR_W-1:0] cursor_x,
    output logic [CUR_W-1:0] cursor_y,
    output logic             cursor_moved,
    output logic [3:0]       btn_level
);
    localparam logic [CUR_W-1:0] X_LIM  = CUR_W'(GRID_COLS - 1);
    localparam logic [CUR_W-1:0] Y_LIM  = CUR_W'(GRID_ROWS - 1);
    localparam logic             WRAP_B = (WRAP != 0);

    logic [NUM_DIRS-1:0] w_raw, w_level, w_event;
    logic [CUR_W-1:0]    r_cur_x, r_cur_y;
    logic                r_moved;
    logic [CUR_W:0]      w_step;
    logic                w_is_x;

    assign w_raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC (REPEAT_RATE_CYC),
            .REPEAT_EN       (REPEAT_EN)
        ) u_cond (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (w_raw[g]),
            .o_level(w_level[g]),
            .o_event(w_event[g])
        );
    end

    // Arbitrate first: a winning move that hits an edge is simply dropped,
    // and losers are never retried.
    always_comb begin
        w_step = '0;
        w_is_x = 1'b0;
        if (w_event[DIR_UP]) begin
            w_step = cur_step(r_cur_y, 1'b1, Y_LIM, WRAP_B);
        end else if (w_event[DIR_DOWN]) begin
            w_step = cur_step(r_cur_y, 1'b0, Y_LIM, WRAP_B);
        end else if (w_event[DIR_LEFT]) begin
            w_step = cur_step(r_cur_x, 1'b1, X_LIM, WRAP_B);
            w_is_x = 1'b1;
        end else if (w_event[DIR_RIGHT]) begin
            w_step = cur_step(r_cur_x, 1'b0, X_LIM, WRAP_B);
            w_is_x = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_moved <= 1'b0;
        end else begin
            r_moved <= w_step[CUR_W];
            if (w_step[CUR_W]) begin
                if (w_is_x) r_cur_x <= w_step[CUR_W-1:0];
                else        r_cur_y <= w_step[CUR_W-1:0];
            end
        end
    end

    assign cursor_x     = r_cur_x;
    assign cursor_y     = r_cur_y;
    assign cursor_moved = r_moved;
    assign btn_level    = w_level;

endmodule

// File: tb/tb_keypad_cursor_nav.sv
// Bench for keypad_cursor_nav: a saturating and a wrapping instance share the
// same button stimulus and are checked every cycle against a behavioural model.
module tb_keypad_cursor_nav;
    localparam int D    = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [3:0] cx0, cy0, lv0, cx1, cy1, lv1;
    logic       mv0, mv1;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_cursor_nav #(.DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE),
                        .REPEAT_EN(1), .GRID_COLS(4), .GRID_ROWS(4), .WRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .cursor_x(cx0), .cursor_y(cy0),
        .cursor_moved(mv0), .btn_level(lv0));

    keypad_cursor_nav #(.DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE),
                        .REPEAT_EN(1), .GRID_COLS(4), .GRID_ROWS(4), .WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .cursor_x(cx1), .cursor_y(cy1),
        .cursor_moved(mv1), .btn_level(lv1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: level follows the synchronized input once it has differed for D
    // cycles; a held button fires at age 0, DLY, DLY+RATE, ...; cursor moves
    // one cycle later with priority by lowest direction index.
    logic [3:0] raw, s1, s2, mlvl;
    int run[4], age[4], mx[2], my[2];
    logic [1:0] mmv;
    assign raw = {btn_right, btn_left, btn_down, btn_up};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 = '0; s2 = '0; mlvl = '0; mmv = '0;
            for (int i = 0; i < 4; i++) begin run[i] = 0; age[i] = 0; end
            for (int k = 0; k < 2; k++) begin mx[k] = 0; my[k] = 0; end
        end else begin
            int win;
            int nx, ny;
            logic [3:0] nlvl;
            win = -1;
            for (int i = 3; i >= 0; i--)
                if (mlvl[i] && (age[i] == 0 || (age[i] >= DLY && (age[i] - DLY) % RATE == 0)))
                    win = i;
            for (int k = 0; k < 2; k++) begin
                nx = mx[k]; ny = my[k]; mmv[k] = 1'b0;
                case (win)
                    0: ny = ny - 1;
                    1: ny = ny + 1;
                    2: nx = nx - 1;
                    3: nx = nx + 1;
                    default: ;
                endcase
                if (k == 1) begin nx = (nx + 4) % 4; ny = (ny + 4) % 4; end
                if (nx >= 0 && nx < 4 && ny >= 0 && ny < 4 && (nx != mx[k] || ny != my[k])) begin
                    mx[k] = nx; my[k] = ny; mmv[k] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (s2[i] != mlvl[i]) run[i] = run[i] + 1;
                else                  run[i] = 0;
                nlvl[i] = mlvl[i];
                if (run[i] == D) begin nlvl[i] = ~mlvl[i]; run[i] = 0; end
                if (nlvl[i] && !mlvl[i]) age[i] = 0;
                else if (nlvl[i])        age[i] = age[i] + 1;
                else                     age[i] = 0;
            end
            mlvl = nlvl; s2 = s1; s1 = raw;
        end
    end

    always @(negedge clk) begin
        chk("x0", cx0, mx[0]);   chk("y0", cy0, my[0]);
        chk("mv0", mv0, mmv[0]); chk("lvl0", lv0, mlvl);
        chk("x1", cx1, mx[1]);   chk("y1", cy1, my[1]);
        chk("mv1", mv1, mmv[1]); chk("lvl1", lv1, mlvl);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int d, input logic v);
        case (d)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic press(input int d);
        set_btn(d, 1'b1); tick(10);
        set_btn(d, 1'b0); tick(15);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        tick(3);
        #2 rst_n = 1'b1;
        tick(50);
        chk("idle_x", cx0, 0); chk("idle_y", cy0, 0); chk("idle_lvl", lv0, 0);

        // 3-cycle glitch is rejected
        btn_right = 1'b1; tick(3); btn_right = 1'b0; tick(12);
        chk("glitch_lvl", lv0, 0); chk("glitch_x", cx0, 0);

        // clean press: new x exactly 7 edges after first sampled 1
        btn_right = 1'b1; tick(6);
        chk("press_x_early", cx0, 0);
        tick(1);
        chk("press_x", cx0, 1); chk("press_mv", mv0, 1);
        tick(1);
        chk("press_mv_clr", mv0, 0);
        tick(2); btn_right = 1'b0; tick(20);

        // hold down: press, +20, +28, saturate at +36
        btn_down = 1'b1; tick(7);
        chk("hold_y1", cy0, 1); chk("hold_mv1", mv0, 1);
        tick(20); chk("hold_y2", cy0, 2);
        tick(8);  chk("hold_y3", cy0, 3);
        tick(8);  chk("hold_sat_y", cy0, 3); chk("hold_sat_mv", mv0, 0);
        chk("hold_wrap_y", cy1, 0);
        tick(17); btn_down = 1'b0; tick(20);

        // wrap at the low edges
        do_reset();
        press(2);
        chk("wrap_x1", cx1, 3); chk("sat_x0", cx0, 0);
        press(0);
        chk("wrap_y1", cy1, 3); chk("sat_y0", cy0, 0);

        // simultaneous up+right from (1,1)
        do_reset();
        press(3); press(1);
        chk("pre_x", cx0, 1); chk("pre_y", cy0, 1);
        btn_up = 1'b1; btn_right = 1'b1; tick(7);
        chk("sim_x0", cx0, 1); chk("sim_y0", cy0, 0); chk("sim_mv0", mv0, 1);
        chk("sim_x1", cx1, 1); chk("sim_y1", cy1, 0);
        tick(20);
        chk("rep_x0", cx0, 1); chk("rep_y0", cy0, 0); chk("rep_mv0", mv0, 0);
        chk("rep_x1", cx1, 1); chk("rep_y1", cy1, 3); chk("rep_mv1", mv1, 1);
        tick(8);
        chk("rep2_x1", cx1, 1); chk("rep2_y1", cy1, 2);
        btn_up = 1'b0; btn_right = 1'b0; tick(20);

        // reset in HELD_REPEAT with the button still held
        btn_down = 1'b1; tick(40);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_x", cx0, 0); chk("rst_y", cy0, 0); chk("rst_lvl", lv0, 0); chk("rst_mv", mv0, 0);
        tick(3);
        #2 rst_n = 1'b1;
        tick(6); chk("rerel_y_early", cy0, 0);
        tick(1); chk("rerel_y", cy0, 1); chk("rerel_mv", mv0, 1);
        btn_down = 1'b0; tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
